// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: types, access-size encodings and payload helper shared by the memory arbiter.
package mem_arb_pkg;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_access_size_t;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_I,
        OWNER_D,
        OWNER_S
    } arb_owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [1:0]            size;
        logic                  read_unsigned;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_arb_req_t;

    function automatic mem_arb_req_t make_req(
        input logic                  we,
        input logic [1:0]            size,
        input logic                  read_unsigned,
        input logic [MEM_ADDR_W-1:0] addr,
        input logic [MEM_DATA_W-1:0] wdata
    );
        return '{we: we, size: size, read_unsigned: read_unsigned, addr: addr, wdata: wdata};
    endfunction
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts enabled cycles since clear; expire marks the TIMEOUT-th one.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    assign expire = en && (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: one single-ported memory shared by fetch (I), data (D) and setup loader (S).
// S has absolute priority, I/D alternate round-robin; define MEM_ARB_PERF_EN for perf counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              setup_write,
    input  logic [ADDR_W-1:0] setup_address,
    input  logic [DATA_W-1:0] setup_data_in,
    output logic              setup_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic              mem_unsigned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic              busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants,
    output logic [CNT_W-1:0]  i_stall_cycles,
    output logic [CNT_W-1:0]  d_stall_cycles
`endif
);
    arb_state_t   state_q, state_d;
    arb_owner_t   owner_q, owner_d, rr_q, rr_d, win;
    mem_arb_req_t req_q, req_d;
    logic         wd_clr, wd_expire, done;
    logic [DATA_W-1:0] rdata_sel;

    // On a tie the requester that did not finish last wins.
    assign win = setup_write     ? OWNER_S :
                 (i_req && d_req) ? ((rr_q == OWNER_I) ? OWNER_D : OWNER_I) :
                 i_req           ? OWNER_I :
                 d_req           ? OWNER_D : OWNER_NONE;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        req_d   = req_q;
        wd_clr  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ARB_IDLE: if (win != OWNER_NONE) begin
                state_d = ARB_REQ;
                owner_d = win;
                req_d   = (win == OWNER_S) ? make_req(1'b1, SIZE_WORD, 1'b0, MEM_ADDR_W'(setup_address), MEM_DATA_W'(setup_data_in)) :
                          (win == OWNER_I) ? make_req(1'b0, SIZE_WORD, 1'b0, MEM_ADDR_W'(i_addr), '0) :
                                             make_req(d_we, d_size, d_unsigned, MEM_ADDR_W'(d_addr), MEM_DATA_W'(d_wdata));
            end
            ARB_REQ: if (mem_ready) begin
                state_d = ARB_WAIT;
                wd_clr  = 1'b1;
            end
            ARB_WAIT: if (mem_rvalid || wd_expire) begin
                state_d = ARB_IDLE;
                owner_d = OWNER_NONE;
                done    = 1'b1;
                if (owner_q == OWNER_I || owner_q == OWNER_D)
                    rr_d = owner_q;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (state_q == ARB_WAIT),
        .expire (wd_expire)
    );

    // An aborted transaction returns zero data.
    assign rdata_sel = mem_rvalid ? mem_rdata : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_NONE;
            rr_q      <= OWNER_I;
            req_q     <= '0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            setup_ack <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            req_q     <= req_d;
            i_rvalid  <= done && owner_q == OWNER_I;
            d_rvalid  <= done && owner_q == OWNER_D && !req_q.we;
            setup_ack <= done && owner_q == OWNER_S && mem_rvalid;
            err       <= done && !mem_rvalid;
            if (done && owner_q == OWNER_I)
                i_rdata <= rdata_sel;
            if (done && owner_q == OWNER_D && !req_q.we)
                d_rdata <= rdata_sel;
        end
    end

    assign i_gnt        = (state_q == ARB_REQ) && mem_ready && (owner_q == OWNER_I);
    assign d_gnt        = (state_q == ARB_REQ) && mem_ready && (owner_q == OWNER_D);
    assign mem_req      = state_q == ARB_REQ;
    assign mem_we       = req_q.we;
    assign mem_size     = req_q.size;
    assign mem_unsigned = req_q.read_unsigned;
    assign mem_addr     = ADDR_W'(req_q.addr);
    assign mem_wdata    = DATA_W'(req_q.wdata);
    assign busy         = state_q != ARB_IDLE;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_grants       <= '0;
            d_grants       <= '0;
            i_stall_cycles <= '0;
            d_stall_cycles <= '0;
        end else begin
            if (i_gnt && !(&i_grants))
                i_grants <= i_grants + 1'b1;
            if (d_gnt && !(&d_grants))
                d_grants <= d_grants + 1'b1;
            if (i_req && !i_gnt && !(&i_stall_cycles))
                i_stall_cycles <= i_stall_cycles + 1'b1;
            if (d_req && !d_gnt && !(&d_stall_cycles))
                d_stall_cycles <= d_stall_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural 1-cycle memory.
// Define MEM_ARB_PERF_EN to also exercise the perf counters.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 64;
    localparam int CW = 16;

    logic        clock = 0, reset = 0;
    logic        i_req = 0, d_req = 0, d_we = 0, d_unsigned = 0, setup_write = 0;
    logic [1:0]  d_size = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, setup_address = 0, setup_data_in = 0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, setup_ack, mem_req, mem_we, mem_unsigned, err, busy;
    logic [1:0]  mem_size;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        mem_ready = 0, mem_rvalid = 0;
    logic [31:0] mem_rdata = 0;
`ifdef MEM_ARB_PERF_EN
    logic [CW-1:0] i_grants, d_grants, i_stall_cycles, d_stall_cycles;
    int i_stall_m = 0, d_stall_m = 0;
`endif

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .setup_write(setup_write), .setup_address(setup_address), .setup_data_in(setup_data_in),
        .setup_ack(setup_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err(err), .busy(busy)
`ifdef MEM_ARB_PERF_EN
        , .i_grants(i_grants), .d_grants(d_grants),
        .i_stall_cycles(i_stall_cycles), .d_stall_cycles(d_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0, failed = 0;
    logic [31:0] exp_i[$], exp_d[$];
    logic [7:0]  exp_gnt[$];
    int exp_ack = 0, exp_err = 0;

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Backing memory: ready unless stalled, completion one cycle after acceptance.
    logic [31:0] mem [logic [31:0]];
    int stall_cnt = 0;
    bit mute = 0, inject = 0, pending = 0;
    logic [31:0] pend_data = 0;

    always @(posedge clock) begin
        #1;
        mem_rvalid = 0;
        if (!reset) begin
            pending = 0;
            mem_ready = 0;
        end else begin
            if (pending && !mute) begin
                mem_rvalid = 1;
                mem_rdata = pend_data;
            end else if (inject) begin
                mem_rvalid = 1;
                mem_rdata = 32'hBAD0BAD0;
                inject = 0;
            end
            pending = 0;
            mem_ready = (stall_cnt == 0);
            if (stall_cnt > 0 && mem_req) stall_cnt--;
            if (mem_req && mem_ready) begin
                pending = 1;
                if (mem_we) mem[mem_addr] = mem_wdata;
                pend_data = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clock) begin
`ifdef MEM_ARB_PERF_EN
        if (!reset) begin
            i_stall_m = 0;
            d_stall_m = 0;
        end else begin
            if (i_req && !i_gnt) i_stall_m++;
            if (d_req && !d_gnt) d_stall_m++;
        end
`endif
        if (reset) begin
            if (mem_rvalid) check("rvalid_during_req", mem_req, 0);
            if (i_gnt || d_gnt) begin
                if (exp_gnt.size() == 0) check("gnt_unexpected", {i_gnt, d_gnt}, 0);
                else check("gnt_order", (i_gnt && d_gnt) ? "B" : i_gnt ? "I" : "D", exp_gnt.pop_front());
            end
            if (i_rvalid) begin
                if (exp_i.size() == 0) check("i_rvalid_unexpected", i_rvalid, 0);
                else check("i_rdata", i_rdata, exp_i.pop_front());
            end
            if (d_rvalid) begin
                if (exp_d.size() == 0) check("d_rvalid_unexpected", d_rvalid, 0);
                else check("d_rdata", d_rdata, exp_d.pop_front());
            end
            if (setup_ack) begin
                check("setup_ack_expected", exp_ack > 0, setup_ack);
                if (exp_ack > 0) exp_ack--;
            end
            if (err) begin
                check("err_expected", exp_err > 0, err);
                if (exp_err > 0) exp_err--;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic wait_gnt(input bit is_i, input string n);
        bit seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clock);
            seen = is_i ? i_gnt : d_gnt;
        end
        check(n, seen, 1);
        tick;
    endtask

    task automatic wait_idle(input string n);
        bit idle = 0;
        for (int k = 0; k < 300 && !idle; k++) begin
            @(negedge clock);
            idle = !busy;
        end
        check(n, idle, 1);
    endtask

    task automatic do_i(input logic [31:0] a, input logic [31:0] exp);
        tick;
        exp_gnt.push_back("I");
        exp_i.push_back(exp);
        i_addr = a;
        i_req = 1;
        wait_gnt(1, "i_gnt_seen");
        i_req = 0;
        wait_idle("i_done_idle");
    endtask

    task automatic do_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp);
        tick;
        exp_gnt.push_back("D");
        if (!we) exp_d.push_back(exp);
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        d_size = SIZE_WORD;
        d_req = 1;
        wait_gnt(0, "d_gnt_seen");
        d_req = 0;
        wait_idle("d_done_idle");
    endtask

    task automatic run_rr(input int n);
        int g = 0;
        tick;
        for (int k = 0; k < n; k++) exp_gnt.push_back((k % 2 == 0) ? "D" : "I");
        for (int k = 0; k < n / 2; k++) begin
            exp_i.push_back(32'h11112222);
            exp_d.push_back(32'h33334444);
        end
        i_addr = 32'h10;
        d_addr = 32'h20;
        d_we = 0;
        d_size = SIZE_WORD;
        i_req = 1;
        d_req = 1;
        for (int k = 0; k < 400 && g < n; k++) begin
            @(negedge clock);
            if (i_gnt || d_gnt) g++;
        end
        check("rr_grant_count", g, n);
        tick;
        i_req = 0;
        d_req = 0;
        wait_idle("rr_idle");
    endtask

    task automatic check_reset_outs(input string t);
        check({t, "_ctl"}, {i_gnt, i_rvalid, d_gnt, d_rvalid, setup_ack, mem_req, mem_we, mem_unsigned, err, busy}, 0);
        check({t, "_mem_addr"}, mem_addr, 0);
        check({t, "_mem_wdata"}, mem_wdata, 0);
        check({t, "_mem_size"}, mem_size, 0);
        check({t, "_i_rdata"}, i_rdata, 0);
        check({t, "_d_rdata"}, d_rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen, early;
        int cnt, stalled, bad;
        mem[32'h10] = 32'h11112222;
        mem[32'h20] = 32'h33334444;
        #1;
        check_reset_outs("reset0");
        repeat (3) @(negedge clock);
        check_reset_outs("reset1");
        reset = 1;

        // Round-robin with both held: D first since rr_last defaults to I.
        run_rr(8);

        // Setup beats a pending fetch; the fetch then sees the written word.
        tick;
        setup_address = 32'h100;
        setup_data_in = 32'hDEADBEEF;
        setup_write = 1;
        i_addr = 32'h100;
        i_req = 1;
        exp_ack++;
        exp_gnt.push_back("I");
        exp_i.push_back(32'hDEADBEEF);
        seen = 0;
        early = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clock);
            early |= i_gnt;
            seen = setup_ack;
        end
        setup_write = 0;
        setup_address = 0;
        setup_data_in = 0;
        check("setup_ack_seen", seen, 1);
        check("setup_before_fetch", early, 0);
        wait_gnt(1, "fetch_after_setup_gnt");
        i_req = 0;
        wait_idle("setup_fetch_idle");

        // Memory not ready for 5 cycles.
        tick;
        stall_cnt = 5;
        exp_gnt.push_back("I");
        exp_i.push_back(32'h33334444);
        i_addr = 32'h20;
        i_req = 1;
        stalled = 0;
        bad = 0;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clock);
            if (mem_req && !i_gnt) begin
                stalled++;
                if (mem_addr !== 32'h20 || mem_we !== 1'b0 || mem_size !== SIZE_WORD) bad++;
            end
            if (i_gnt) begin
                seen = 1;
                check("gnt_on_ready", mem_ready, 1);
            end
        end
        check("stall_cycles", stalled, 5);
        check("stall_payload_stable", bad, 0);
        tick;
        i_req = 0;
        wait_idle("stall_idle");

        // Watchdog abort, then a late completion that must be ignored.
        tick;
        mute = 1;
        exp_gnt.push_back("I");
        exp_i.push_back(32'h0);
        exp_err++;
        i_addr = 32'h10;
        i_req = 1;
        wait_gnt(1, "timeout_gnt");
        i_req = 0;
        cnt = 0;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clock);
            cnt++;
            seen = err;
        end
        check("timeout_latency", cnt, TO + 1);
        check("timeout_rvalid", i_rvalid, 1);
        check("timeout_idle", busy, 0);
        mute = 0;
        tick;
        inject = 1;
        repeat (4) @(negedge clock);
        check("late_rvalid_busy", busy, 0);
        check("late_rvalid_rdata", i_rdata, 0);

        // Store produces no d_rvalid; the load returns the stored word.
        do_d(1, 32'h40, 32'h12345678, 0);
        check("store_reached_mem", mem.exists(32'h40) ? mem[32'h40] : 32'h0, 32'h12345678);
        do_d(0, 32'h40, 0, 32'h12345678);

        // Async reset while waiting on the memory.
        tick;
        mute = 1;
        exp_gnt.push_back("I");
        i_addr = 32'h10;
        i_req = 1;
        wait_gnt(1, "abort_gnt");
        i_req = 0;
        repeat (3) @(negedge clock);
        check("in_wait_busy", busy, 1);
        check("in_wait_mem_req", mem_req, 0);
        #2;
        reset = 0;
        #1;
        check_reset_outs("reset_mid");
`ifdef MEM_ARB_PERF_EN
        check("perf_rst_i_grants", i_grants, 0);
        check("perf_rst_d_grants", d_grants, 0);
        check("perf_rst_i_stall", i_stall_cycles, 0);
        check("perf_rst_d_stall", d_stall_cycles, 0);
`endif
        @(negedge clock);
        reset = 1;
        mute = 0;

        // rr_last was D before reset; reset must restore it to I.
        run_rr(4);
`ifdef MEM_ARB_PERF_EN
        check("perf_i_grants", i_grants, 2);
        check("perf_d_grants", d_grants, 2);
        check("perf_i_stall", i_stall_cycles, i_stall_m);
        check("perf_d_stall", d_stall_cycles, d_stall_m);
`endif
        do_i(32'h100, 32'hDEADBEEF);

        repeat (4) @(negedge clock);
        check("left_i", exp_i.size(), 0);
        check("left_d", exp_d.size(), 0);
        check("left_gnt", exp_gnt.size(), 0);
        check("left_ack", exp_ack, 0);
        check("left_err", exp_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported backing memory between three requesters: instruction fetch (I), data load/store (D) and the test setup loader (S).
- Replaces the separate imem/dmem instances in the core. Moves the core toward a unified memory and stall-driven multi-cycle fetch/execute.
- One transaction outstanding at a time. S has absolute priority; I and D alternate round-robin.
- A watchdog aborts transactions the memory never answers.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, max cycles in WAIT before abort; must be >= 2
- CNT_W, 16, width of perf counters (optional feature only)

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; hold with stable i_addr until i_gnt
- i_addr  in  ADDR_W  fetch address (always word read, unsigned)
- i_gnt  out  1  one-cycle pulse: fetch accepted by memory
- i_rvalid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  DATA_W  fetched word
- d_req  in  1  data request; hold with stable payload until d_gnt
- d_we  in  1  1=store, 0=load
- d_size  in  2  mem_access_size (byte/half/word)
- d_unsigned  in  1  load zero-extension
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse, loads only
- d_rdata  out  DATA_W  load data
- setup_write  in  1  level; word write of setup_data_in to setup_address
- setup_address  in  ADDR_W  setup address
- setup_data_in  in  DATA_W  setup data
- setup_ack  out  1  one-cycle pulse: setup write completed
- mem_req  out  1  request to backing memory
- mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata  out  1/2/1/ADDR_W/DATA_W  registered payload
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory completion; asserted once per transaction, reads and writes
- mem_rdata  in  DATA_W  read data
- err  out  1  one-cycle pulse: watchdog abort
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0, async): state=IDLE, rr_last=I, owner=NONE. All outputs 0, including mem payload registers and rdata registers.
- FSM states:
  - IDLE. Winner chosen as S if setup_write, else round-robin between I and D; the requester not equal to rr_last wins a tie. On a winner: latch owner and payload into mem_* regs, go to REQ. If no request, stay in IDLE.
  - REQ. mem_req=1. When mem_ready=1: pulse the owner's gnt (I/D only) this same cycle, drop mem_req next cycle, clear watchdog, go to WAIT.
  - WAIT. On mem_rvalid=1: register mem_rdata into the owner's rdata and pulse the owner's rvalid next cycle. d_rvalid pulses only if !d_we. A setup owner gets setup_ack. Update rr_last when owner is I or D. Go to IDLE.
- Latency: request seen at cycle 0 -> mem_req at cycle 1. With mem_ready=1 and a 1-cycle memory, gnt at cycle 1, mem_rvalid at cycle 2, rvalid/rdata at cycle 3. Next arbitration at cycle 3.
- Watchdog:
  - Counter counts WAIT cycles.
  - When it reaches TIMEOUT without mem_rvalid: err pulses, owner's rvalid pulses with rdata=0, go to IDLE.
  - rr_last still updates.
  - A late mem_rvalid arriving in IDLE/REQ is ignored.
- mem_rvalid while in REQ is ignored (protocol violation; assertion in bench).
- Setup uses mem_size=word, mem_we=1. Setup is re-arbitrated every IDLE while setup_write is high. The bench changes address/data after each setup_ack.
- Requesters dropping req before gnt: illegal (assertion). The arbiter uses its latched payload regardless.
- Reset mid-transaction: immediate return to IDLE. No gnt/rvalid/ack is generated for the aborted transaction. The backing memory shares the reset.
- rdata registers hold their last value between rvalid pulses.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds output ports i_grants, d_grants, i_stall_cycles, d_stall_cycles, each CNT_W.
  - Grant counters increment on each gnt pulse.
  - Stall counters increment each cycle the requester's req=1 and gnt=0.
  - All counters saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Add package mem_arb_pkg holding:
  - enum arb_owner_t {OWNER_NONE, OWNER_I, OWNER_D, OWNER_S}
  - enum arb_state_t {ARB_IDLE, ARB_REQ, ARB_WAIT}
  - struct mem_arb_req_t {we, size, read_unsigned, addr, wdata}
- Reuse mem_pkg access-size/op encodings.
- One sub-module is natural: mem_arb_watchdog, a TIMEOUT counter with clear/enable/expire.

Test Plan:
- I and D held from cycle 0, rr_last=I after reset-default, 1-cycle memory -> D granted first, then I. Grants continue to alternate, D,I,D,I, over 8 transactions.
- setup_write with address 0x100, data 0xDEADBEEF, while i_req=1 -> mem write issued first, setup_ack pulses. A subsequent I read of 0x100 returns i_rdata=0xDEADBEEF.
- D store to 0x40 (d_we=1, wdata 0x12345678) -> d_gnt pulses, no d_rvalid. A following D load, word, of 0x40 -> d_rvalid with 0x12345678.
- mem_ready held 0 for 5 cycles -> mem_req stays 1 and payload stays stable. Gnt pulses exactly on the cycle mem_ready rises.
- No mem_rvalid for TIMEOUT=64 WAIT cycles -> err and i_rvalid pulse with i_rdata=0, then IDLE. A late mem_rvalid is ignored.
- reset driven low during WAIT -> outputs 0 asynchronously and FSM in IDLE. With MEM_ARB_PERF_EN defined, counters read 0 after reset and are correct after 4 grants.
